// File: rtl/mema_lane_if.sv
// Downstream chunk stream of one matrix-A lane consumer.
// The consumer owns data/valid/last; the MAC unit owns ready.
interface mema_lane_if #(
  parameter int unsigned data_w = 256
);
  logic [data_w-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/mema_lane_consumer.sv
// Consumer end of the matrix-A chunk interface: walks one row chunk by chunk,
// waits the provider latency, captures each chunk and hands it downstream.
module mema_lane_consumer #(
  parameter int unsigned element_width = 32,
  parameter int unsigned no_of_units   = 8,
  parameter int unsigned fetch_latency = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 read_preprocess,
  input  logic [31:0]                          no_of_multiples,
  input  logic [element_width*no_of_units-1:0] chunk_in,
  output logic                                 I_am_ready,
  output logic [31:0]                          chunk_index,
  mema_lane_if.master                          bus,
  output logic                                 busy,
  output logic                                 done
);
  localparam int unsigned chunk_w = element_width * no_of_units;
  localparam logic [3:0]  lat     = 4'(fetch_latency);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FIN} state_t;

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic [31:0]          n_rows, n_rows_next;
  logic [31:0]          idx, idx_next;
  logic                 toggle, toggle_next;
  logic [chunk_w-1:0]   data, data_next;
  logic                 valid, valid_next;
  logic                 last, last_next;
  logic                 busy_q, busy_next;
  logic                 done_q, done_next;

  // next-state and next-output logic for the row walk
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    n_rows_next = n_rows;
    idx_next    = idx;
    toggle_next = toggle;
    data_next   = data;
    valid_next  = valid;
    last_next   = last;
    case (state)
      IDLE: begin
        if (read_preprocess) begin
          if (no_of_multiples != 32'd0) begin
            n_rows_next = no_of_multiples;
            idx_next    = 32'd1;
            cnt_next    = lat;
            state_next  = WAIT;
          end else begin
            state_next  = FIN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        // capture in the cycle the countdown hits zero so valid rises one cycle later
        if (cnt == 4'd1) begin
          data_next  = chunk_in;
          valid_next = 1'b1;
          last_next  = (idx == n_rows);
          cnt_next   = 4'd0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (valid && bus.out_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (idx < n_rows) begin
            idx_next    = idx + 32'd1;
            toggle_next = ~toggle;
            cnt_next    = lat;
            state_next  = WAIT;
          end else begin
            state_next  = FIN;
          end
        end else begin
          state_next = HOLD;
        end
      end
      FIN: begin
        idx_next   = 32'd1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == FIN);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      n_rows <= 32'd0;
      idx    <= 32'd1;
      toggle <= 1'b0;
      data   <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      n_rows <= n_rows_next;
      idx    <= idx_next;
      toggle <= toggle_next;
      data   <= data_next;
      valid  <= valid_next;
      last   <= last_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  assign I_am_ready    = toggle;
  assign chunk_index   = idx;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_mema_lane_consumer.sv
// Randomized bench for mema_lane_consumer against a cycle-level walk model.
module tb_mema_lane_consumer;
  localparam int unsigned LAT = 2;
  localparam int unsigned W   = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_preprocess;
  logic [31:0]   no_of_multiples;
  logic [W-1:0]  chunk_in;
  logic          i_am_ready;
  logic [31:0]   chunk_index;
  logic          busy;
  logic          done;

  mema_lane_if #(.data_w(W)) bus ();

  mema_lane_consumer #(.element_width(32), .no_of_units(8), .fetch_latency(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_preprocess (read_preprocess),
    .no_of_multiples (no_of_multiples),
    .chunk_in        (chunk_in),
    .I_am_ready      (i_am_ready),
    .chunk_index     (chunk_index),
    .bus             (bus.master),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   pcount = 0;
  logic ir_model = 1'b0;
  logic [15:0] tag;

  // provider side: every edge of the toggle line advances its index
  always @(i_am_ready) pcount = pcount + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // chunk k: every element carries the walk tag, k and its element number (element 0 in MS slice)
  function automatic logic [W-1:0] pat(input logic [15:0] t, input int unsigned k);
    logic [W-1:0] p;
    logic [7:0]   kb;
    logic [7:0]   eb;
    kb = 8'(k);
    for (int e = 0; e < 8; e++) begin
      eb = 8'(e);
      p[W-1-32*e -: 32] = {t, kb, eb};
    end
    return p;
  endfunction

  function automatic logic [W-1:0] garbage();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_reset_vals();
    check("rst_ir",    {255'd0, i_am_ready},    {W{1'b0}});
    check("rst_index", {224'd0, chunk_index},   {224'd0, 32'd1});
    check("rst_data",  bus.out_data,            {W{1'b0}});
    check("rst_valid", {255'd0, bus.out_valid}, {W{1'b0}});
    check("rst_last",  {255'd0, bus.out_last},  {W{1'b0}});
    check("rst_busy",  {255'd0, busy},          {W{1'b0}});
    check("rst_done",  {255'd0, done},          {W{1'b0}});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    read_preprocess = 1'b0;
    @(negedge clk);
    ir_model = 1'b0;
    check_reset_vals();
    reset = 1'b0;
  endtask

  // one row walk; cycle 0 is the start cycle, checks are made mid-cycle
  task automatic run_walk(input int unsigned n, input int ready_pct, input bit stray,
                          input bit abort2, input int hold_first);
    int base;
    int beat;
    int nxt;
    int done_cyc;
    int flip_cyc;
    int held;
    bit vexp;
    tag      = 16'($urandom());
    base     = pcount;
    beat     = 1;
    nxt      = LAT + 1;
    done_cyc = (n == 0) ? 1 : -1;
    flip_cyc = -1;
    held     = 0;
    read_preprocess = 1'b1;
    no_of_multiples = n;
    chunk_in        = garbage();
    bus.out_ready   = ($urandom_range(99) < 50);
    for (int cyc = 1; ; cyc++) begin
      @(negedge clk);
      read_preprocess = 1'b0;
      no_of_multiples = $urandom();
      if (cyc == flip_cyc) ir_model = ~ir_model;
      check("ir",   {255'd0, i_am_ready}, {255'd0, ir_model});
      check("done", {255'd0, done}, {255'd0, (cyc == done_cyc)});
      check("busy", {255'd0, busy}, {255'd0, (done_cyc < 0 || cyc <= done_cyc)});
      if (done_cyc >= 0 && cyc > done_cyc) begin
        check("toggles", W'(pcount - base), W'((n == 0) ? 0 : n - 1));
        break;
      end
      if (cyc > 3000) begin
        check("timeout", {255'd0, 1'b1}, {W{1'b0}});
        break;
      end
      vexp = (n != 0 && beat <= n && cyc >= nxt);
      check("valid", {255'd0, bus.out_valid}, {255'd0, vexp});
      chunk_in      = garbage();
      bus.out_ready = ($urandom_range(99) < ready_pct);
      if (vexp) begin
        check("data",  bus.out_data, pat(tag, beat));
        check("last",  {255'd0, bus.out_last}, {255'd0, (beat == n)});
        check("index", {224'd0, chunk_index}, W'(beat));
        if (beat == 1 && held < hold_first) begin
          bus.out_ready = 1'b0;
          held++;
        end
        if (bus.out_ready) begin
          if (beat == n) begin
            done_cyc = cyc + 1;
          end else begin
            nxt      = cyc + 1 + LAT;
            flip_cyc = cyc + 1;
          end
          beat++;
        end
      end else if (n != 0 && beat <= n && cyc == nxt - 1) begin
        chunk_in = pat(tag, pcount - base + 1);
      end
      if (abort2 && beat == 2 && !vexp && cyc < nxt - 1) begin
        reset = 1'b1;
        return;
      end
      if ((stray && $urandom_range(3) == 0) || cyc == done_cyc) begin
        read_preprocess = 1'b1;
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    read_preprocess = 1'b0;
    no_of_multiples = 32'd0;
    chunk_in        = {W{1'b0}};
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    run_walk(3, 100, 1'b0, 1'b0, 0);
    run_walk(0, 100, 1'b0, 1'b0, 0);
    run_walk(2, 100, 1'b0, 1'b0, 5);
    run_walk(4, 100, 1'b1, 1'b0, 0);
    run_walk(5, 100, 1'b0, 1'b1, 0);
    @(negedge clk);
    ir_model = 1'b0;
    check_reset_vals();
    reset = 1'b0;
    run_walk(1, 100, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_walk($urandom_range(0, 6), $urandom_range(20, 100), 1'($urandom_range(1)), 1'b0, 0);
      if ($urandom_range(9) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
